mac_dot_sequencer: RTL and testbench
====================================

# mac_dot_sequencer

Upstream control stage for the iterative shift-add multiplier (start/ready handshake). It accepts a stream of operand pairs over a valid/ready interface and issues one multiplier transaction per pair. It accumulates the returned products into a dot-product sum and presents the sum downstream with a valid/ready handshake once the configured vector length has been processed.

## Interface

Parameters:
- DATA_WIDTH, 8, operand width; matches multiplier m_in/q_in.
- ACC_WIDTH, 16, product width; matches multiplier product.
- SUM_WIDTH, 24, accumulator and output width; must be ≥ ACC_WIDTH.
- LEN_WIDTH, 4, width of the vector-length field.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_len  in  LEN_WIDTH  terms per dot product; sampled with the first pair of a vector.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  pair accepted when in_valid && in_ready.
- in_m  in  DATA_WIDTH  multiplicand.
- in_q  in  DATA_WIDTH  multiplier.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_m  out  DATA_WIDTH  registered multiplicand to multiplier.
- mul_q  out  DATA_WIDTH  registered multiplier to multiplier.
- mul_product  in  ACC_WIDTH  multiplier result.
- mul_ready  in  1  multiplier done/idle level.
- out_valid  out  1  sum valid.
- out_ready  in  1  downstream accept.
- out_sum  out  SUM_WIDTH  accumulated dot product.
- out_ovf  out  1  overflow occurred in this vector.

## Operation

- FSM states: IDLE, START, GAP, WAIT, OUT.
- IDLE: in_ready=1. On handshake, latch in_m/in_q into mul_m/mul_q and go to START. On the first pair of a vector (term count 0), latch cfg_len, clear the sum and clear out_ovf. cfg_len=0 is treated as 1.
- START: mul_start=1 for exactly this cycle. Go to GAP.
- GAP: one cycle; mul_ready is ignored so that a stale idle-high ready is not mistaken for completion. Go to WAIT.
- WAIT: hold until mul_ready=1. In that cycle, zero-extend mul_product to SUM_WIDTH, add it to the sum, and increment the term count.
- After the WAIT capture: if the new count equals the latched length, go to OUT. Otherwise return to IDLE.
- OUT: out_valid=1. out_sum and out_ovf are held stable. On out_valid && out_ready, reset the term count to 0 and go to IDLE.
- in_ready is 0 in every state except IDLE. Pairs offered outside IDLE are not consumed.
- Unsigned arithmetic throughout.
- mul_m/mul_q hold their values from acceptance until the next acceptance.

## Timing

- Reset (asynchronous assert, synchronous release): state=IDLE, in_ready=1, mul_start=0, mul_m=0, mul_q=0, out_valid=0, out_sum=0, out_ovf=0, term count=0.
- Accept at edge N: mul_start is high during cycle N+1, GAP is N+2, WAIT starts at N+3.
- Product captured at the edge where mul_ready=1 in WAIT. in_ready returns high the next cycle for a non-final term; for the final term, out_valid goes high the next cycle.
- Minimum cost per term is 4 cycles plus multiplier latency.
- in_ready is a function of the registered state only; it does not depend combinationally on in_valid.
- Reset mid-operation: the FSM aborts immediately, the partial sum is discarded and mul_start drops asynchronously. The multiplier is reset by the same rst_n.
- Back-to-back vectors: a new vector's first pair is accepted in the IDLE cycle after the OUT handshake.

## Configuration

- MAC_SAT_EN defined: the addition saturates at 2^SUM_WIDTH−1. out_ovf is set sticky for the vector on any saturating add, and further adds keep the sum at all-ones.
- MAC_SAT_EN undefined: the sum wraps modulo 2^SUM_WIDTH and out_ovf is tied to 0.

## Test plan

- Basic dot product: cfg_len=3, pairs (2,3),(4,5),(6,7), multiplier model latency 8 → single out_valid with out_sum=68, out_ovf=0; exactly 3 mul_start pulses, each 1 cycle wide.
- Saturation with SUM_WIDTH=16, cfg_len=2, pairs (255,255),(255,255):
  - MAC_SAT_EN defined → out_sum=0xFFFF, out_ovf=1.
  - MAC_SAT_EN undefined → out_sum=64514, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid, out_sum and out_ovf stay stable and in_ready=0 throughout; handshake on cycle 6, in_ready=1 on cycle 7.
- Stale ready: model keeps mul_ready=1 when idle and drops it one cycle after start, latency 4 → the product is captured after the real completion, not in the GAP cycle; cfg_len=1, pair (9,9) → out_sum=81.
- Reset mid-operation: assert rst_n=0 while in WAIT of term 2 of 3 → all outputs take their reset values immediately. A subsequent cfg_len=1, pair (3,3) → out_sum=9, with no residue from the aborted vector.
- cfg_len=0 with pair (5,6) → treated as length 1, out_sum=30. Then a back-to-back vector with cfg_len=2, pairs (1,1),(1,1) → out_sum=2.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: issues one shift-add multiplier transaction per accepted operand pair
// and accumulates the products into a dot-product sum. Build option: MAC_SAT_EN (saturating sum).
module mac_dot_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int SUM_WIDTH  = 24,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_m,
    input  logic [DATA_WIDTH-1:0] in_q,
    output logic                  mul_start,
    output logic [DATA_WIDTH-1:0] mul_m,
    output logic [DATA_WIDTH-1:0] mul_q,
    input  logic [ACC_WIDTH-1:0]  mul_product,
    input  logic                  mul_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_WIDTH-1:0]  out_sum,
    output logic                  out_ovf
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    logic [2:0]            state_reg, state_next;
    logic [DATA_WIDTH-1:0] mul_m_reg, mul_q_reg;
    logic [LEN_WIDTH-1:0]  term_cnt_reg, len_reg;
    logic [SUM_WIDTH-1:0]  sum_reg, sum_next;

    logic                  accept;
    logic                  capture;
    logic                  out_fire;
    logic                  first_term;
    logic                  last_term;
    logic [LEN_WIDTH-1:0]  cnt_inc;
    logic [LEN_WIDTH-1:0]  len_eff;

    // Handshake outputs decode the registered state only, so reset clears them at once.
    assign in_ready  = (state_reg == IDLE);
    assign mul_start = (state_reg == START);
    assign out_valid = (state_reg == OUT);
    assign mul_m     = mul_m_reg;
    assign mul_q     = mul_q_reg;
    assign out_sum   = sum_reg;

    assign accept     = in_valid && in_ready;
    assign capture    = (state_reg == WAIT) && mul_ready;
    assign out_fire   = out_valid && out_ready;
    assign first_term = (term_cnt_reg == '0);
    assign cnt_inc    = term_cnt_reg + LEN_WIDTH'(1);
    assign last_term  = (cnt_inc == len_reg);
    assign len_eff    = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;

`ifdef MAC_SAT_EN
    logic                 ovf_reg, ovf_next;
    logic [SUM_WIDTH:0]   add_full;

    assign add_full = {1'b0, sum_reg} + {1'b0, SUM_WIDTH'(mul_product)};

    // A carry out of the top bit clamps the sum to all-ones; the flag stays set for the vector.
    always_comb begin
        sum_next = add_full[SUM_WIDTH-1:0];
        ovf_next = ovf_reg;
        if (add_full[SUM_WIDTH]) begin
            sum_next = '1;
            ovf_next = 1'b1;
        end
    end

    assign out_ovf = ovf_reg;
`else
    always_comb begin
        sum_next = sum_reg + SUM_WIDTH'(mul_product);
    end

    assign out_ovf = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = START;
            START:   state_next = GAP;
            // GAP exists so an idle-high mul_ready from before the start is never taken as done.
            GAP:     state_next = WAIT;
            WAIT:    if (mul_ready) state_next = last_term ? OUT : IDLE;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_m_reg    <= '0;
            mul_q_reg    <= '0;
            term_cnt_reg <= '0;
            len_reg      <= LEN_WIDTH'(1);
            sum_reg      <= '0;
`ifdef MAC_SAT_EN
            ovf_reg      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                mul_m_reg <= in_m;
                mul_q_reg <= in_q;
                // The first pair of a vector fixes its length and starts a fresh sum.
                if (first_term) begin
                    len_reg <= len_eff;
                    sum_reg <= '0;
`ifdef MAC_SAT_EN
                    ovf_reg <= 1'b0;
`endif
                end
            end
            if (capture) begin
                sum_reg      <= sum_next;
                term_cnt_reg <= cnt_inc;
`ifdef MAC_SAT_EN
                ovf_reg      <= ovf_next;
`endif
            end
            if (out_fire) begin
                term_cnt_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: a behavioural multiplier model with configurable latency and
// idle-high ready, directed scenarios, and random vectors checked against a plain-arithmetic dot product.
`timescale 1ns/1ps
module tb_mac_dot_sequencer;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int SW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_m = '0;
    logic [DW-1:0] in_q = '0;
    logic          mul_start;
    logic [DW-1:0] mul_m, mul_q;
    logic [AW-1:0] mdl_prod;
    logic          mdl_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_sum;
    logic          out_ovf;

    int n_cmp = 0;
    int n_err = 0;

    mac_dot_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SUM_WIDTH(SW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q),
        .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
        .mul_product(mdl_prod), .mul_ready(mdl_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // Multiplier model: ready is an idle-high level; the product is junk until completion.
    // In stale mode ready stays high through the cycle after the start pulse.
    int            lat = 8;
    bit            stale = 1'b0;
    int            mdl_cnt;
    logic [DW-1:0] mdl_m, mdl_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt   <= 0;
            mdl_ready <= 1'b1;
            mdl_prod  <= '0;
            mdl_m     <= '0;
            mdl_q     <= '0;
        end else if (mul_start) begin
            mdl_cnt   <= lat;
            mdl_m     <= mul_m;
            mdl_q     <= mul_q;
            mdl_ready <= stale;
            mdl_prod  <= 16'hDEAD;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                mdl_ready <= 1'b1;
                mdl_prod  <= AW'(mdl_m * mdl_q);
            end else begin
                mdl_ready <= 1'b0;
            end
        end
    end

    int   start_cnt = 0;
    int   start_wide = 0;
    logic start_d = 1'b0;
    always @(posedge clk) begin
        if (mul_start) start_cnt <= start_cnt + 1;
        if (mul_start && start_d) start_wide <= start_wide + 1;
        start_d <= mul_start;
    end

    logic [DW-1:0] vm [16];
    logic [DW-1:0] vq [16];

    // Reference: the dot product in wide integer arithmetic, then clamped or wrapped.
    task automatic ref_dot(input int n, output logic [SW-1:0] s, output logic o);
        longint total = 0;
        longint maxv = (longint'(1) << SW) - 1;
        for (int i = 0; i < n; i++) total += longint'(vm[i]) * longint'(vq[i]);
`ifdef MAC_SAT_EN
        if (total > maxv) begin s = '1; o = 1'b1; end
        else begin s = SW'(total); o = 1'b0; end
`else
        s = SW'(total % (maxv + 1));
        o = 1'b0;
`endif
    endtask

    // All driver tasks start and return at a falling edge.
    task automatic send_pair(input logic [DW-1:0] m, input logic [DW-1:0] q, input logic [LW-1:0] len,
                             output int waited, output bit ok);
        waited = 0;
        ok = 1'b1;
        in_valid = 1'b1; in_m = m; in_q = q; cfg_len = len;
        while (!in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 500) begin
                ok = 1'b0;
                in_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int hold, output logic [SW-1:0] s, output logic o, output bit ok);
        int t = 0;
        ok = 1'b1;
        s = '0;
        o = 1'b0;
        while (!out_valid) begin
            @(negedge clk);
            t++;
            if (t > 1000) begin ok = 1'b0; return; end
        end
        s = out_sum;
        o = out_ovf;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_vector(input logic [LW-1:0] len, input int hold,
                              output logic [SW-1:0] s, output logic o, output bit ok);
        int  n = (len == 0) ? 1 : int'(len);
        int  w;
        bit  pok;
        ok = 1'b1;
        s = '0;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_pair(vm[i], vq[i], len, w, pok);
            if (!pok) begin ok = 1'b0; return; end
        end
        wait_out(hold, s, o, ok);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({in_ready, mul_start, mul_m, mul_q, out_valid, out_sum, out_ovf} !== {1'b1, 1'b0, 8'h0, 8'h0, 1'b0, 16'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got rdy=%b st=%b m=%h q=%h ov=%b sum=%h ovf=%b want rdy=1 others 0",
                     in_ready, mul_start, mul_m, mul_q, out_valid, out_sum, out_ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_timing();
        logic [SW-1:0] s; logic o; bit ok;
        lat = 3;
        in_valid = 1'b1; in_m = 8'd10; in_q = 8'd11; cfg_len = 4'd1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({mul_start, in_ready, mul_m, mul_q} !== {1'b1, 1'b0, 8'd10, 8'd11}) begin
            n_err++;
            $display("FAIL start_cycle got st=%b rdy=%b m=%0d q=%0d want st=1 rdy=0 m=10 q=11", mul_start, in_ready, mul_m, mul_q);
        end
        @(negedge clk);
        n_cmp++;
        if ({mul_start, in_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL gap_cycle got st=%b rdy=%b want 0 0", mul_start, in_ready);
        end
        wait_out(0, s, o, ok);
        n_cmp++;
        if (!ok || s !== 16'd110) begin n_err++; $display("FAIL timing_sum got %0d ok=%0d want 110", s, ok); end
        $display("test_timing sum=%0d", s);
    endtask

    task automatic test_basic();
        logic [SW-1:0] s, es; logic o, eo; bit ok;
        int s0 = start_cnt;
        int w0 = start_wide;
        lat = 8;
        vm[0] = 8'd2; vq[0] = 8'd3; vm[1] = 8'd4; vq[1] = 8'd5; vm[2] = 8'd6; vq[2] = 8'd7;
        ref_dot(3, es, eo);
        run_vector(4'd3, 0, s, o, ok);
        n_cmp++;
        if (!ok || s !== 16'd68 || s !== es || o !== 1'b0) begin
            n_err++; $display("FAIL basic_sum got %0d ovf=%b ok=%0d want 68 ovf=0", s, o, ok);
        end
        n_cmp++;
        if (start_cnt - s0 != 3 || start_wide != w0) begin
            n_err++; $display("FAIL basic_starts got %0d pulses wide=%0d want 3 wide=0", start_cnt - s0, start_wide - w0);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_single_out got out_valid=%b want 0", out_valid); end
        $display("test_basic sum=%0d starts=%0d", s, start_cnt - s0);
    endtask

    task automatic test_saturation();
        logic [SW-1:0] s; logic o; bit ok;
        logic [SW-1:0] want_s;
        logic          want_o;
`ifdef MAC_SAT_EN
        want_s = 16'hFFFF; want_o = 1'b1;
`else
        want_s = 16'd64514; want_o = 1'b0;
`endif
        lat = 2;
        vm[0] = 8'd255; vq[0] = 8'd255; vm[1] = 8'd255; vq[1] = 8'd255;
        run_vector(4'd2, 1, s, o, ok);
        n_cmp++;
        if (!ok || s !== want_s || o !== want_o) begin
            n_err++; $display("FAIL saturation got %0d ovf=%b ok=%0d want %0d ovf=%b", s, o, ok, want_s, want_o);
        end
        $display("test_saturation sum=%0d ovf=%b", s, o);
    endtask

    task automatic test_backpressure();
        int  w; bit ok; int t = 0;
        lat = 2;
        send_pair(8'd12, 8'd13, 4'd1, w, ok);
        while (!out_valid && t < 200) begin @(negedge clk); t++; end
        n_cmp++;
        if (!ok || !out_valid) begin n_err++; $display("FAIL bp_timeout got out_valid=%b want 1", out_valid); end
        for (int k = 1; k <= 6; k++) begin
            n_cmp++;
            if ({out_valid, out_sum, out_ovf, in_ready} !== {1'b1, 16'd156, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold_c%0d got ov=%b sum=%0d ovf=%b rdy=%b want 1 156 0 0", k, out_valid, out_sum, out_ovf, in_ready);
            end
            if (k == 6) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++; $display("FAIL bp_release got rdy=%b ov=%b want 1 0", in_ready, out_valid);
        end
        $display("test_backpressure sum=156 held 5 cycles");
    endtask

    task automatic test_stale_ready();
        logic [SW-1:0] s; logic o; bit ok;
        stale = 1'b1; lat = 4;
        vm[0] = 8'd9; vq[0] = 8'd9;
        run_vector(4'd1, 0, s, o, ok);
        n_cmp++;
        if (!ok || s !== 16'd81 || o !== 1'b0) begin
            n_err++; $display("FAIL stale_ready got %0d ovf=%b ok=%0d want 81", s, o, ok);
        end
        stale = 1'b0;
        $display("test_stale_ready sum=%0d", s);
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] s; logic o; bit ok; int w;
        lat = 8;
        send_pair(8'd7, 8'd8, 4'd3, w, ok);
        send_pair(8'd5, 8'd9, 4'd3, w, ok);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok || mul_m !== 8'd5 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_pre got m=%0d rdy=%b ok=%0d want m=5 rdy=0", mul_m, in_ready, ok);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, mul_start, mul_m, mul_q, out_valid, out_sum, out_ovf} !== {1'b1, 1'b0, 8'h0, 8'h0, 1'b0, 16'h0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset got rdy=%b st=%b m=%h q=%h ov=%b sum=%h ovf=%b want rdy=1 others 0",
                     in_ready, mul_start, mul_m, mul_q, out_valid, out_sum, out_ovf);
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        send_pair(8'd4, 8'd4, 4'd2, w, ok);
        n_cmp++;
        if (mul_start !== 1'b1) begin n_err++; $display("FAIL abort_pre got mul_start=%b want 1", mul_start); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mul_start, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL abort_start got st=%b rdy=%b want 0 1", mul_start, in_ready);
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        vm[0] = 8'd3; vq[0] = 8'd3;
        run_vector(4'd1, 0, s, o, ok);
        n_cmp++;
        if (!ok || s !== 16'd9 || o !== 1'b0) begin
            n_err++; $display("FAIL after_reset got %0d ovf=%b ok=%0d want 9", s, o, ok);
        end
        $display("test_reset_mid sum=%0d", s);
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] s; logic o; bit ok, pok; int w;
        lat = 3;
        vm[0] = 8'd5; vq[0] = 8'd6;
        run_vector(4'd0, 0, s, o, ok);
        n_cmp++;
        if (!ok || s !== 16'd30) begin n_err++; $display("FAIL len_zero got %0d ok=%0d want 30", s, ok); end
        send_pair(8'd1, 8'd1, 4'd2, w, pok);
        n_cmp++;
        if (!pok || w != 0) begin n_err++; $display("FAIL b2b_accept got wait=%0d want 0", w); end
        send_pair(8'd1, 8'd1, 4'd2, w, pok);
        wait_out(0, s, o, ok);
        n_cmp++;
        if (!ok || !pok || s !== 16'd2) begin n_err++; $display("FAIL b2b_sum got %0d ok=%0d want 2", s, ok); end
        $display("test_back_to_back sums 30 then %0d", s);
    endtask

    task automatic test_random();
        logic [SW-1:0] s, es; logic o, eo; bit ok;
        logic [LW-1:0] len;
        int n;
        for (int v = 0; v < 20; v++) begin
            len = LW'($urandom_range(0, 15));
            n = (len == 0) ? 1 : int'(len);
            for (int i = 0; i < 16; i++) begin
                vm[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : DW'($urandom);
                vq[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : DW'($urandom);
            end
            lat = $urandom_range(1, 6);
            stale = $urandom_range(0, 1) == 1;
            ref_dot(n, es, eo);
            run_vector(len, $urandom_range(0, 3), s, o, ok);
            n_cmp++;
            if (!ok || s !== es || o !== eo) begin
                n_err++; $display("FAIL random_%0d got %0d ovf=%b ok=%0d want %0d ovf=%b", v, s, o, ok, es, eo);
            end
            $display("random vec %0d len=%0d lat=%0d stale=%0d sum=%0d ovf=%b", v, len, lat, stale, s, o);
        end
        stale = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_basic();
        test_saturation();
        test_backpressure();
        test_stale_ready();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
